tmr_clock_gate_ctrl: RTL and testbench
======================================

Name: tmr_clock_gate_ctrl

Overview:
Parametrised, triplication-hardened clock-gate controller for NCH clock domains. Holds a per-channel gating mode (OFF / ON / AUTO) in three internally voted, self-scrubbing copies. Produces one registered gate-enable per channel to drive ICG cells. AUTO mode gates a channel off after IDLE_CYCLES of inactivity and wakes it on activity. Sits between the slow-control register bank and the clock tree; SEU-induced mismatches are flagged and counted.

Parameters:
NCH, 3, number of gated clock channels (1..32)
IDLE_CYCLES, 16, consecutive idle cycles before AUTO gates off (>=1)
CNT_W, 8, width of saturating TMR error counter
RST_MODE, 2'b01, mode loaded into all copies at reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_wr  in  1  write strobe for one channel's mode
cfg_ch  in  clog2(NCH) (min 1)  target channel of cfg_wr
cfg_mode  in  2  00 OFF, 01 ON, 10 AUTO, 11 reserved (= ON)
activity  in  NCH  per-channel activity request (AUTO wake/keep-alive)
inj_en  in  1  test-only SEU injection strobe
inj_ch  in  clog2(NCH) (min 1)  injection channel
inj_copy  in  2  copy to upset: 0=A, 1=B, 2=C, 3 = no-op
inj_bit  in  1  mode bit to flip
gate_en  out  NCH  registered gate enable per channel
tmr_err  out  1  one-cycle pulse, mismatch seen among copies
err_cnt  out  CNT_W  saturating count of mismatch cycles

Behaviour:
- Per channel: copies mA, mB, mC (2 b each). voted = bitwise majority(mA, mB, mC).
- Each edge, every copy <= voted (scrub). Exceptions, in priority order:
  - cfg_wr && cfg_ch==i: all three copies <= cfg_mode.
  - else inj_en && inj_ch==i && inj_copy!=3: selected copy <= voted ^ (1<<inj_bit); other two scrub.
- cfg_ch / inj_ch >= NCH: ignored.
- Mismatch: any channel with copies not all equal in the current cycle -> tmr_err=1 at next edge; err_cnt+1 at the same edge, saturating at all-ones.
- A single upset never reaches gate_en. It is repaired at the following edge, so tmr_err pulses exactly once.
- gate_en[i] next value from voted mode:
  - OFF: 0.
  - ON or 11: 1.
  - AUTO:
    - activity[i]=1 -> gate_en=1, idle_cnt=0.
    - else if idle_cnt==IDLE_CYCLES-1 -> gate_en=0, idle_cnt holds.
    - else idle_cnt+1, gate_en holds.
- idle_cnt is cleared whenever voted mode is not AUTO. On entering AUTO, counting starts from 0.
- Latency:
  - cfg_wr at edge k -> copies updated at k; gate_en reflects the new mode at k+1.
  - activity at edge k -> gate_en=1 at k.
  - After the last activity sample at edge k, gate_en falls at edge k+IDLE_CYCLES.
- Reset (rst=1 at an edge):
  - all copies = RST_MODE; gate_en = all ones; idle_cnt = 0; tmr_err = 0; err_cnt = 0.
  - Reset overrides cfg_wr and inj_en in the same cycle.
  - Mid-operation reset discards pending idle counts.
- No combinational path from any input to any output.

Test Plan:
- Reset with RST_MODE=01 -> gate_en=3'b111, err_cnt=0, tmr_err=0; hold 5 cycles, outputs unchanged.
- cfg_wr ch1 mode 00 -> gate_en[1]=0 two edges after the strobe; other channels stay 1; tmr_err never asserts.
- ch0 AUTO, IDLE_CYCLES=16, activity[0] pulsed once then low -> gate_en[0] falls 16 edges after the pulse sample. Re-pulse -> gate_en[0]=1 at the sampling edge.
- inj_en ch2 copy B bit 0 with mode ON -> gate_en[2] stays 1; tmr_err high exactly one cycle; err_cnt=1; copies equal again.
- Same-cycle cfg_wr and inj_en on ch0 (mode 10) -> cfg wins; no tmr_err; err_cnt unchanged.
- CNT_W=2, five injections on separate cycles -> err_cnt saturates at 3. Then rst -> err_cnt=0, gate_en all ones.

Source files
------------

// File: rtl/tmr_clock_gate_ctrl.sv
// Clock-gate controller: per-channel OFF/ON/AUTO mode held in three voted,
// self-scrubbing copies, driving one registered ICG enable per channel.
module tmr_clock_gate_ctrl #(
  parameter int         NCH         = 3,
  parameter int         IDLE_CYCLES = 16,
  parameter int         CNT_W       = 8,
  parameter logic [1:0] RST_MODE    = 2'b01
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_wr,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                             cfg_mode,
  input  logic [NCH-1:0]                         activity,
  input  logic                                   inj_en,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] inj_ch,
  input  logic [1:0]                             inj_copy,
  input  logic                                   inj_bit,
  output logic [NCH-1:0]                         gate_en,
  output logic                                   tmr_err,
  output logic [CNT_W-1:0]                       err_cnt
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b10;

  logic [NCH-1:0][1:0]    r_mode_a, r_mode_b, r_mode_c;
  logic [NCH-1:0][IW-1:0] r_idle;
  logic [NCH-1:0]         r_gate;
  logic                   r_err;
  logic [CNT_W-1:0]       r_cnt;

  logic [NCH-1:0][1:0]    w_voted, w_nxt_a, w_nxt_b, w_nxt_c;
  logic [NCH-1:0][IW-1:0] w_idle_nxt;
  logic [NCH-1:0]         w_gate_nxt;
  logic [NCH-1:0]         w_mis;
  logic                   w_any_mis;
  logic [1:0]             w_flip;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_flip    = inj_bit ? 2'b10 : 2'b01;
  assign w_any_mis = |w_mis;

  // Vote, mismatch detect and next-copy selection (cfg beats injection)
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_voted[i] = (r_mode_a[i] & r_mode_b[i]) | (r_mode_a[i] & r_mode_c[i]) |
                   (r_mode_b[i] & r_mode_c[i]);
      w_mis[i]   = (r_mode_a[i] != r_mode_b[i]) || (r_mode_b[i] != r_mode_c[i]);
      w_nxt_a[i] = w_voted[i];
      w_nxt_b[i] = w_voted[i];
      w_nxt_c[i] = w_voted[i];
      if (cfg_wr && (cfg_ch == CH_W'(i))) begin
        w_nxt_a[i] = cfg_mode;
        w_nxt_b[i] = cfg_mode;
        w_nxt_c[i] = cfg_mode;
      end else if (inj_en && (inj_ch == CH_W'(i))) begin
        case (inj_copy)
          2'd0:    w_nxt_a[i] = w_voted[i] ^ w_flip;
          2'd1:    w_nxt_b[i] = w_voted[i] ^ w_flip;
          2'd2:    w_nxt_c[i] = w_voted[i] ^ w_flip;
          default: ;
        endcase
      end
    end
  end

  // Gate decision from the voted mode; reserved 11 behaves as ON
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_gate_nxt[i] = r_gate[i];
      w_idle_nxt[i] = r_idle[i];
      case (w_voted[i])
        MODE_OFF: begin
          w_gate_nxt[i] = 1'b0;
          w_idle_nxt[i] = '0;
        end
        MODE_AUTO: begin
          if (activity[i]) begin
            w_gate_nxt[i] = 1'b1;
            w_idle_nxt[i] = '0;
          end else if (r_idle[i] == IDLE_LAST) begin
            w_gate_nxt[i] = 1'b0;
          end else begin
            w_idle_nxt[i] = r_idle[i] + IW'(1);
          end
        end
        default: begin
          w_gate_nxt[i] = 1'b1;
          w_idle_nxt[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_a <= {NCH{RST_MODE}};
      r_mode_b <= {NCH{RST_MODE}};
      r_mode_c <= {NCH{RST_MODE}};
      r_idle   <= '0;
      r_gate   <= '1;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_mode_a <= w_nxt_a;
      r_mode_b <= w_nxt_b;
      r_mode_c <= w_nxt_c;
      r_idle   <= w_idle_nxt;
      r_gate   <= w_gate_nxt;
      r_err    <= w_any_mis;
      if (w_any_mis) r_cnt <= sat_inc(r_cnt);
    end
  end

  assign gate_en = r_gate;
  assign tmr_err = r_err;
  assign err_cnt = r_cnt;
endmodule

// File: tb/tb_tmr_clock_gate_ctrl.sv
// Scoreboard bench for tmr_clock_gate_ctrl: a behavioural model pushes the
// expected outputs for every edge; each scenario task pops and compares them.
module tb_tmr_clock_gate_ctrl;
  localparam int         NCH   = 3;
  localparam int         IDLE  = 16;
  localparam int         CNT_W = 2;
  localparam logic [1:0] RSTM  = 2'b01;

  typedef struct packed {
    logic [NCH-1:0]   gate;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, cfg_wr, inj_en, inj_bit;
  logic [1:0] cfg_ch, cfg_mode, inj_ch, inj_copy;
  logic [NCH-1:0] activity;
  logic [NCH-1:0] gate_en;
  logic tmr_err;
  logic [CNT_W-1:0] err_cnt;

  exp_t sb[$];
  exp_t e, got;
  int n_chk = 0;
  int n_fail = 0;

  logic [1:0]     m_mode [NCH];
  int             m_since[NCH];
  logic [NCH-1:0] m_gate;
  logic           m_pend, m_err;
  int             m_cnt;

  tmr_clock_gate_ctrl #(.NCH(NCH), .IDLE_CYCLES(IDLE), .CNT_W(CNT_W), .RST_MODE(RSTM)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .activity(activity), .inj_en(inj_en), .inj_ch(inj_ch), .inj_copy(inj_copy),
    .inj_bit(inj_bit), .gate_en(gate_en), .tmr_err(tmr_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic idle_inputs();
    rst = 1'b0; cfg_wr = 1'b0; cfg_ch = 2'd0; cfg_mode = 2'd0; activity = '0;
    inj_en = 1'b0; inj_ch = 2'd0; inj_copy = 2'd3; inj_bit = 1'b0;
  endtask

  // Model one clock edge with the current inputs, queue the result, advance.
  task automatic tick();
    exp_t x;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin m_mode[i] = RSTM; m_since[i] = 0; end
      m_gate = '1; m_pend = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_err = m_pend;
      if (m_pend && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      for (int i = 0; i < NCH; i++) begin
        if (m_mode[i] == 2'b00) begin
          m_gate[i] = 1'b0; m_since[i] = 0;
        end else if (m_mode[i] == 2'b10) begin
          if (activity[i]) begin
            m_gate[i] = 1'b1; m_since[i] = 0;
          end else begin
            if (m_since[i] < IDLE) m_since[i]++;
            if (m_since[i] >= IDLE) m_gate[i] = 1'b0;
          end
        end else begin
          m_gate[i] = 1'b1; m_since[i] = 0;
        end
      end
      m_pend = inj_en && (int'(inj_ch) < NCH) && (inj_copy != 2'd3) &&
               !(cfg_wr && cfg_ch == inj_ch);
      if (cfg_wr && int'(cfg_ch) < NCH) m_mode[cfg_ch] = cfg_mode;
    end
    x.gate = m_gate; x.err = m_err; x.cnt = m_cnt[CNT_W-1:0];
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
    e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL reset_sb: got %h want %h", got, e); end
    n_chk++;
    if (gate_en !== 3'b111 || tmr_err !== 1'b0 || err_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_vals: got %b/%b/%0d want 111/0/0", gate_en, tmr_err, err_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset_hold c%0d: got %h want %h", c, got, e); end
    end
  endtask

  task automatic test_cfg();
    // ch1 OFF, then reserved 11 on ch1, then an out-of-range channel
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 0) begin cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b00; end
      if (c == 3) begin cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b11; end
      if (c == 5) begin cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'b00; end
      tick(); idle_inputs();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL cfg_sb c%0d: got %h want %h", c, got, e); end
      if (c == 0) begin
        n_chk++;
        if (gate_en !== 3'b111) begin n_fail++; $display("FAIL cfg_strobe_edge: got %b want 111", gate_en); end
      end
      if (c == 1) begin
        n_chk++;
        if (gate_en !== 3'b101 || tmr_err !== 1'b0) begin
          n_fail++; $display("FAIL cfg_off: got %b/%b want 101/0", gate_en, tmr_err);
        end
      end
      if (c == 6) begin
        n_chk++;
        if (gate_en !== 3'b111) begin n_fail++; $display("FAIL cfg_rsvd_oor: got %b want 111", gate_en); end
      end
    end
  endtask

  task automatic test_auto();
    int n;
    idle_inputs(); cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b10; tick();
    e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL auto_cfg: got %h want %h", got, e); end
    idle_inputs(); activity = 3'b001; tick(); idle_inputs();
    e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL auto_pulse: got %h want %h", got, e); end
    n = 0;
    while (gate_en[0] === 1'b1 && n < 40) begin
      tick(); n++;
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL auto_idle n%0d: got %h want %h", n, got, e); end
    end
    n_chk++;
    if (n != IDLE) begin n_fail++; $display("FAIL auto_fall_delay: got %0d edges want %0d", n, IDLE); end
    for (int c = 0; c < 30; c++) begin
      idle_inputs(); activity[0] = (c % 10 == 0);
      tick(); idle_inputs();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL auto_keep c%0d: got %h want %h", c, got, e); end
      if (c == 0) begin
        n_chk++;
        if (gate_en[0] !== 1'b1) begin n_fail++; $display("FAIL auto_wake: got %b want 1", gate_en[0]); end
      end
    end
  endtask

  task automatic test_inject();
    int pulses = 0;
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c == 0) begin inj_en = 1'b1; inj_ch = 2'd2; inj_copy = 2'd1; inj_bit = 1'b0; end
      if (c == 4) begin inj_en = 1'b1; inj_ch = 2'd1; inj_copy = 2'd3; inj_bit = 1'b1; end
      if (c == 5) begin inj_en = 1'b1; inj_ch = 2'd3; inj_copy = 2'd0; inj_bit = 1'b1; end
      tick(); idle_inputs();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL inject_sb c%0d: got %h want %h", c, got, e); end
      if (tmr_err === 1'b1) pulses++;
      if (c < 4) begin
        n_chk++;
        if (gate_en[2] !== 1'b1) begin n_fail++; $display("FAIL inject_gate c%0d: got %b want 1", c, gate_en[2]); end
      end
    end
    n_chk++;
    if (pulses != 1 || err_cnt !== 2'd1) begin
      n_fail++; $display("FAIL inject_pulse: got %0d pulses cnt %0d want 1 pulse cnt 1", pulses, err_cnt);
    end
  endtask

  task automatic test_cfg_inj_same();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b10;
        inj_en = 1'b1; inj_ch = 2'd0; inj_copy = 2'd0; inj_bit = 1'b1;
      end
      activity[0] = 1'b1;
      tick(); idle_inputs();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL same_cycle_sb c%0d: got %h want %h", c, got, e); end
      n_chk++;
      if (tmr_err !== 1'b0 || err_cnt !== 2'd1) begin
        n_fail++; $display("FAIL same_cycle c%0d: got err %b cnt %0d want 0/1", c, tmr_err, err_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      if (c % 2 == 0 && c < 10) begin
        inj_en = 1'b1; inj_ch = 2'(c % 3); inj_copy = 2'((c / 2) % 3); inj_bit = c[1];
      end
      tick(); idle_inputs();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL saturate_sb c%0d: got %h want %h", c, got, e); end
    end
    n_chk++;
    if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL saturate: got %0d want 3", err_cnt); end
  endtask

  task automatic test_mid_reset();
    // ch0 still AUTO with a pending idle count; reset beats a same-cycle cfg/inj
    idle_inputs(); activity[0] = 1'b1; tick(); idle_inputs();
    e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL midrst_pre: got %h want %h", got, e); end
    for (int c = 0; c < 3; c++) begin
      tick();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL midrst_idle c%0d: got %h want %h", c, got, e); end
    end
    rst = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b00;
    inj_en = 1'b1; inj_ch = 2'd1; inj_copy = 2'd2;
    tick(); idle_inputs();
    e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL midrst_sb: got %h want %h", got, e); end
    n_chk++;
    if (gate_en !== 3'b111 || err_cnt !== 2'd0 || tmr_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_vals: got %b/%b/%0d want 111/0/0", gate_en, tmr_err, err_cnt);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      e = sb.pop_front(); got = {gate_en, tmr_err, err_cnt}; n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL midrst_after c%0d: got %h want %h", c, got, e); end
    end
    n_chk++;
    if (gate_en !== 3'b111 || err_cnt !== 2'd0) begin
      n_fail++; $display("FAIL midrst_hold: got %b/%0d want 111/0", gate_en, err_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    m_gate = '0; m_pend = 1'b0; m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin m_mode[i] = RSTM; m_since[i] = 0; end
    test_reset();
    test_cfg();
    test_auto();
    test_inject();
    test_cfg_inj_same();
    test_saturate();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
